mp_register_file: RTL and testbench
===================================

MP_REGISTER_FILE -- requirements
Module: mp_register_file

Interface
REQ-001 Parameter DATA_W, default 32, width of each register in bits.
REQ-002 Parameter NUM_REGS, default 32, number of registers; power of two, 2..256; ADDR_W = log2(NUM_REGS).
REQ-003 Parameter RD_PORTS, default 2, number of independent read ports; 1..4.
REQ-004 Parameter ZERO_REG, default 1, when 1 register 0 is hardwired to zero.
REQ-005 iClk  in  1  clock; all state updates occur on its rising edge.
REQ-006 iReset  in  1  reset, asynchronous, active-high.
REQ-007 iRaddr  in  RD_PORTS x ADDR_W  read addresses, one per read port.
REQ-008 oRdata  out  RD_PORTS x DATA_W  read data, one per read port.
REQ-009 oRbusy  out  RD_PORTS  scoreboard busy flag of the addressed register, one per read port.
REQ-010 iWe0 / iWaddr0 / iWdata0  in  1 / ADDR_W / DATA_W  write port 0.
REQ-011 iWe1 / iWaddr1 / iWdata1  in  1 / ADDR_W / DATA_W  write port 1.
REQ-012 iIssueValid / iIssueAddr  in  1 / ADDR_W  marks the destination register busy.
REQ-013 oBusyCount  out  ADDR_W+1  number of registers currently marked busy.

Function
REQ-014 Reads are combinational; oRdata[p] shall equal the stored value of iRaddr[p] when no write to that address is active.
REQ-015 Write-first bypass: if any enabled write port targets iRaddr[p] in the current cycle, oRdata[p] shall return that port's iWdata in the same cycle.
REQ-016 On the rising iClk edge with iWeN=1, register iWaddrN shall take iWdataN; both ports may write distinct addresses in the same cycle.
REQ-017 If both write ports target the same address in one cycle, port 1 shall win for storage and for bypass.
REQ-018 When ZERO_REG=1: writes to address 0 are discarded; oRdata reads 0 for address 0; oRbusy reads 0 for address 0; an issue to address 0 is ignored.
REQ-019 Scoreboard: one busy bit per register; iIssueValid=1 sets busy[iIssueAddr] at the clock edge.
REQ-020 An enabled write on either port clears busy[iWaddrN] at the clock edge.
REQ-021 Issue and write to the same address in the same cycle: issue wins and the bit stays set, since a newer producer owns the register.
REQ-022 Issue to an already-busy register shall keep it busy; a write to a non-busy register shall leave it clear; neither is an error.
REQ-023 oRbusy[p] shall reflect the registered busy state only, with no bypass of same-cycle issue or clear.
REQ-024 oBusyCount shall be registered and update together with the busy bits, net of all sets and clears in that cycle.
REQ-025 oBusyCount shall range 0..NUM_REGS (NUM_REGS-1 when ZERO_REG=1) and shall never wrap.

Reset
REQ-026 While iReset=1, all registers shall be 0, all busy bits 0 and oBusyCount 0, independent of iClk.
REQ-027 Reset asserted during a write or issue cycle shall win; no write or issue from that cycle persists.
REQ-028 After reset deasserts, the first rising edge shall perform normal writes and issues.

Structure
REQ-029 A shared package shall hold the default parameter constants and the ADDR_W derivation function.
REQ-030 The scoreboard (busy bits plus oBusyCount) shall be one sub-module, rf_scoreboard; the storage and bypass logic stays in mp_register_file.

Verification
REQ-031 Reset, then read all addresses on every port -> oRdata=0, oRbusy=0, oBusyCount=0.
REQ-032 Write 0xDEADBEEF to r5 on port 0 while reading r5 -> oRdata=0xDEADBEEF in the same cycle and on all later reads.
REQ-033 Port 0 writes 0x1111 to r7 and port 1 writes 0x2222 to r7 in the same cycle -> r7 reads 0x2222; with ZERO_REG=1, a write of 0xFFFF to r0 -> r0 reads 0.
REQ-034 Issue r3, r4, r9 on successive cycles -> oBusyCount 1,2,3; write r4 -> busy[r4]=0, oBusyCount=2.
REQ-035 Issue r3 and write r3 in the same cycle while r3 is busy -> r3 stays busy, oBusyCount unchanged.
REQ-036 Assert iReset mid-cycle with oBusyCount=3 and a pending write of 0xAB to r2 -> all outputs 0 immediately; r2 reads 0 after release.

Source files
------------

// File: rtl/mp_register_file_pkg.sv
// Shared defaults and helpers for the multi-ported register file.
package mp_register_file_pkg;

  localparam int DEF_DATA_W   = 32;
  localparam int DEF_NUM_REGS = 32;
  localparam int DEF_RD_PORTS = 2;
  localparam bit DEF_ZERO_REG = 1'b1;

  // Number of address bits needed to select one of num_regs registers.
  function automatic int calc_addr_w(input int num_regs);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'd1 << i) < num_regs) begin
        w = i + 1;
      end else begin
        w = w;
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/mp_register_file_scoreboard.sv
// Busy-bit scoreboard: one bit per register, set by issue, cleared by writes,
// with a registered population count kept in step with the bits.
module rf_scoreboard
  import mp_register_file_pkg::*;
#(
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter bit ZERO_REG = DEF_ZERO_REG,
  localparam int ADDR_W  = calc_addr_w(NUM_REGS)
) (
  input  logic                iClk,
  input  logic                iReset,
  input  logic                iWe0,
  input  logic [ADDR_W-1:0]   iWaddr0,
  input  logic                iWe1,
  input  logic [ADDR_W-1:0]   iWaddr1,
  input  logic                iIssueValid,
  input  logic [ADDR_W-1:0]   iIssueAddr,
  output logic [NUM_REGS-1:0] oBusy,
  output logic [ADDR_W:0]     oBusyCount
);

  localparam logic [NUM_REGS-1:0] ONE_HOT0 = {{(NUM_REGS-1){1'b0}}, 1'b1};

  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic [NUM_REGS-1:0] clr_mask_s, set_mask_s, zero_mask_s;

  // Next busy state: clears first, then sets, so a same-cycle issue keeps the bit owned.
  always_comb begin
    clr_mask_s  = (iWe0 ? (ONE_HOT0 << iWaddr0) : {NUM_REGS{1'b0}})
                | (iWe1 ? (ONE_HOT0 << iWaddr1) : {NUM_REGS{1'b0}});
    set_mask_s  = iIssueValid ? (ONE_HOT0 << iIssueAddr) : {NUM_REGS{1'b0}};
    zero_mask_s = ZERO_REG ? ONE_HOT0 : {NUM_REGS{1'b0}};
    busy_d      = ((busy_q & ~clr_mask_s) | set_mask_s) & ~zero_mask_s;
  end

  // Count is the population of the next busy vector, so it can never wrap.
  always_comb begin
    count_d = {(ADDR_W+1){1'b0}};
    for (int i = 0; i < NUM_REGS; i++) begin
      count_d = count_d + {{ADDR_W{1'b0}}, busy_d[i]};
    end
  end

  // Busy bits and count share one register stage.
  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      busy_q  <= {NUM_REGS{1'b0}};
      count_q <= {(ADDR_W+1){1'b0}};
    end else begin
      busy_q  <= busy_d;
      count_q <= count_d;
    end
  end

  assign oBusy      = busy_q;
  assign oBusyCount = count_q;

endmodule

// File: rtl/mp_register_file.sv
// Multi-read, dual-write register file with write-first bypass and a busy scoreboard.
module mp_register_file
  import mp_register_file_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int RD_PORTS = DEF_RD_PORTS,
  parameter bit ZERO_REG = DEF_ZERO_REG,
  localparam int ADDR_W  = calc_addr_w(NUM_REGS)
) (
  input  logic                         iClk,
  input  logic                         iReset,
  input  logic [RD_PORTS*ADDR_W-1:0]   iRaddr,
  output logic [RD_PORTS*DATA_W-1:0]   oRdata,
  output logic [RD_PORTS-1:0]          oRbusy,
  input  logic                         iWe0,
  input  logic [ADDR_W-1:0]            iWaddr0,
  input  logic [DATA_W-1:0]            iWdata0,
  input  logic                         iWe1,
  input  logic [ADDR_W-1:0]            iWaddr1,
  input  logic [DATA_W-1:0]            iWdata1,
  input  logic                         iIssueValid,
  input  logic [ADDR_W-1:0]            iIssueAddr,
  output logic [ADDR_W:0]              oBusyCount
);

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] busy_s;
  logic                byp_en0_s, byp_en1_s;

  // Bypass is suppressed during reset so every read returns zero while it is held.
  assign byp_en0_s = iWe0 & ~iReset;
  assign byp_en1_s = iWe1 & ~iReset;

  // Next storage state: port 1 overrides port 0 on an address collision; r0 stays zero when hardwired.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = (iWe1 && (iWaddr1 == ADDR_W'(i))) ? iWdata1 :
                  (iWe0 && (iWaddr0 == ADDR_W'(i))) ? iWdata0 :
                  regs_q[i];
      if (ZERO_REG && (i == 0)) begin
        regs_d[i] = {DATA_W{1'b0}};
      end else begin
        regs_d[i] = regs_d[i];
      end
    end
  end

  // Register storage with asynchronous clear.
  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      regs_q <= '{default: {DATA_W{1'b0}}};
    end else begin
      regs_q <= regs_d;
    end
  end

  genvar gp;
  for (gp = 0; gp < RD_PORTS; gp++) begin : g_rd
    logic [ADDR_W-1:0] raddr_s;
    logic [DATA_W-1:0] rdata_s;

    assign raddr_s = iRaddr[gp*ADDR_W +: ADDR_W];

    // Write-first read: newest same-cycle write (port 1 first) beats stored value.
    always_comb begin
      rdata_s = (byp_en1_s && (iWaddr1 == raddr_s)) ? iWdata1 :
                (byp_en0_s && (iWaddr0 == raddr_s)) ? iWdata0 :
                regs_q[raddr_s];
      if (ZERO_REG && (raddr_s == {ADDR_W{1'b0}})) begin
        rdata_s = {DATA_W{1'b0}};
      end else begin
        rdata_s = rdata_s;
      end
    end

    assign oRdata[gp*DATA_W +: DATA_W] = rdata_s;
    assign oRbusy[gp]                  = busy_s[raddr_s];
  end

  rf_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .iClk        (iClk),
    .iReset      (iReset),
    .iWe0        (iWe0),
    .iWaddr0     (iWaddr0),
    .iWe1        (iWe1),
    .iWaddr1     (iWaddr1),
    .iIssueValid (iIssueValid),
    .iIssueAddr  (iIssueAddr),
    .oBusy       (busy_s),
    .oBusyCount  (oBusyCount)
  );

endmodule

// File: tb/tb_mp_register_file.sv
// Directed bench for mp_register_file with default parameters.
module tb_mp_register_file;

  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 32;
  localparam int RD_PORTS = 2;
  localparam int ADDR_W   = 5;

  logic                       iClk;
  logic                       iReset;
  logic [RD_PORTS*ADDR_W-1:0] iRaddr;
  logic [RD_PORTS*DATA_W-1:0] oRdata;
  logic [RD_PORTS-1:0]        oRbusy;
  logic                       iWe0;
  logic [ADDR_W-1:0]          iWaddr0;
  logic [DATA_W-1:0]          iWdata0;
  logic                       iWe1;
  logic [ADDR_W-1:0]          iWaddr1;
  logic [DATA_W-1:0]          iWdata1;
  logic                       iIssueValid;
  logic [ADDR_W-1:0]          iIssueAddr;
  logic [ADDR_W:0]            oBusyCount;

  int pass_cnt  = 0;
  int total_cnt = 0;

  mp_register_file dut (
    .iClk        (iClk),
    .iReset      (iReset),
    .iRaddr      (iRaddr),
    .oRdata      (oRdata),
    .oRbusy      (oRbusy),
    .iWe0        (iWe0),
    .iWaddr0     (iWaddr0),
    .iWdata0     (iWdata0),
    .iWe1        (iWe1),
    .iWaddr1     (iWaddr1),
    .iWdata1     (iWdata1),
    .iIssueValid (iIssueValid),
    .iIssueAddr  (iIssueAddr),
    .oBusyCount  (oBusyCount)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic set_rd(input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1);
    iRaddr = {a1, a0};
  endtask

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic idle();
    iWe0 = 1'b0; iWe1 = 1'b0; iIssueValid = 1'b0;
  endtask

  initial begin
    iReset = 1'b1;
    iRaddr = '0;
    iWe0 = 1'b0; iWaddr0 = '0; iWdata0 = '0;
    iWe1 = 1'b0; iWaddr1 = '0; iWdata1 = '0;
    iIssueValid = 1'b0; iIssueAddr = '0;

    #12;
    check("count_in_reset", 32'(oBusyCount), 32'd0);
    iReset = 1'b0;
    #1;

    // All addresses read zero and not busy after reset.
    for (int a = 0; a < NUM_REGS; a++) begin
      set_rd(ADDR_W'(a), ADDR_W'(NUM_REGS - 1 - a));
      #1;
      check("rst_rdata_p0", oRdata[31:0], 32'd0);
      check("rst_rdata_p1", oRdata[63:32], 32'd0);
      check("rst_rbusy", 32'(oRbusy), 32'd0);
    end
    check("rst_count", 32'(oBusyCount), 32'd0);

    // Write-first bypass on r5, then stored value.
    tick();
    iWe0 = 1'b1; iWaddr0 = 5'd5; iWdata0 = 32'hDEADBEEF;
    set_rd(5'd5, 5'd5);
    #1;
    check("byp_r5_p0", oRdata[31:0], 32'hDEADBEEF);
    check("byp_r5_p1", oRdata[63:32], 32'hDEADBEEF);
    tick();
    idle();
    set_rd(5'd5, 5'd6);
    #1;
    check("stored_r5", oRdata[31:0], 32'hDEADBEEF);
    check("r6_untouched", oRdata[63:32], 32'd0);

    // Collision on r7: port 1 wins for bypass and storage.
    iWe0 = 1'b1; iWaddr0 = 5'd7; iWdata0 = 32'h1111;
    iWe1 = 1'b1; iWaddr1 = 5'd7; iWdata1 = 32'h2222;
    set_rd(5'd7, 5'd5);
    #1;
    check("byp_r7_collide", oRdata[31:0], 32'h2222);
    check("r5_during_r7", oRdata[63:32], 32'hDEADBEEF);
    tick();
    idle();
    #1;
    check("stored_r7", oRdata[31:0], 32'h2222);

    // Distinct dual write.
    iWe0 = 1'b1; iWaddr0 = 5'd12; iWdata0 = 32'hA5A5A5A5;
    iWe1 = 1'b1; iWaddr1 = 5'd13; iWdata1 = 32'h5A5A5A5A;
    tick();
    idle();
    set_rd(5'd12, 5'd13);
    #1;
    check("dual_r12", oRdata[31:0], 32'hA5A5A5A5);
    check("dual_r13", oRdata[63:32], 32'h5A5A5A5A);

    // r0 hardwired to zero.
    iWe0 = 1'b1; iWaddr0 = 5'd0; iWdata0 = 32'hFFFF;
    set_rd(5'd0, 5'd0);
    #1;
    check("r0_bypass", oRdata[31:0], 32'd0);
    tick();
    idle();
    #1;
    check("r0_stored", oRdata[63:32], 32'd0);

    // Scoreboard: issue r3, r4, r9.
    iIssueValid = 1'b1; iIssueAddr = 5'd3;
    set_rd(5'd3, 5'd4);
    #1;
    check("busy_no_bypass", 32'(oRbusy[0]), 32'd0);
    tick();
    check("count_1", 32'(oBusyCount), 32'd1);
    check("busy_r3", 32'(oRbusy[0]), 32'd1);
    iIssueAddr = 5'd4;
    tick();
    check("count_2", 32'(oBusyCount), 32'd2);
    check("busy_r4", 32'(oRbusy[1]), 32'd1);
    iIssueAddr = 5'd9;
    tick();
    check("count_3", 32'(oBusyCount), 32'd3);
    idle();

    // Write r4 clears its busy bit.
    iWe0 = 1'b1; iWaddr0 = 5'd4; iWdata0 = 32'h44;
    tick();
    idle();
    #1;
    check("r4_cleared", 32'(oRbusy[1]), 32'd0);
    check("count_after_clr", 32'(oBusyCount), 32'd2);

    // Issue and write r3 together while busy: stays busy, data stored.
    iIssueValid = 1'b1; iIssueAddr = 5'd3;
    iWe1 = 1'b1; iWaddr1 = 5'd3; iWdata1 = 32'h33;
    tick();
    idle();
    #1;
    check("r3_still_busy", 32'(oRbusy[0]), 32'd1);
    check("count_unchanged", 32'(oBusyCount), 32'd2);
    check("r3_data", oRdata[31:0], 32'h33);

    // Issue to r0 ignored; write to non-busy r10 leaves count alone.
    iIssueValid = 1'b1; iIssueAddr = 5'd0;
    iWe0 = 1'b1; iWaddr0 = 5'd10; iWdata0 = 32'h10;
    tick();
    idle();
    set_rd(5'd0, 5'd10);
    #1;
    check("r0_not_busy", 32'(oRbusy[0]), 32'd0);
    check("r10_not_busy", 32'(oRbusy[1]), 32'd0);
    check("count_r0_issue", 32'(oBusyCount), 32'd2);

    // Bring count to 3 with r4, then reset mid-cycle during a write of r2.
    iIssueValid = 1'b1; iIssueAddr = 5'd4;
    tick();
    idle();
    check("count_pre_rst", 32'(oBusyCount), 32'd3);
    iWe0 = 1'b1; iWaddr0 = 5'd2; iWdata0 = 32'hAB;
    iIssueValid = 1'b1; iIssueAddr = 5'd20;
    set_rd(5'd2, 5'd3);
    #1;
    check("r2_byp_pre_rst", oRdata[31:0], 32'hAB);
    #1;
    iReset = 1'b1;
    #1;
    check("rst_mid_count", 32'(oBusyCount), 32'd0);
    check("rst_mid_rdata0", oRdata[31:0], 32'd0);
    check("rst_mid_rdata1", oRdata[63:32], 32'd0);
    check("rst_mid_rbusy", 32'(oRbusy), 32'd0);
    tick();
    idle();
    iReset = 1'b0;
    #1;
    check("r2_after_rst", oRdata[31:0], 32'd0);
    check("count_after_rst", 32'(oBusyCount), 32'd0);
    set_rd(5'd20, 5'd5);
    #1;
    check("r20_not_busy", 32'(oRbusy[0]), 32'd0);
    check("r5_cleared", oRdata[63:32], 32'd0);

    // First edge after reset performs normal operations.
    iWe0 = 1'b1; iWaddr0 = 5'd2; iWdata0 = 32'h55;
    iIssueValid = 1'b1; iIssueAddr = 5'd9;
    tick();
    idle();
    set_rd(5'd2, 5'd9);
    #1;
    check("post_rst_write", oRdata[31:0], 32'h55);
    check("post_rst_busy", 32'(oRbusy[1]), 32'd1);
    check("post_rst_count", 32'(oBusyCount), 32'd1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
